// File: rtl/bus_downsizer_if.sv
// bus_downsizer_if: word-side and beat-side valid/ready signals of bus_downsizer.
// last_src exists only when BUS_DOWNSIZER_LAST_EN is defined.
interface bus_downsizer_if #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 8
);
    logic                 valid_dnt;
    logic [WIDTH-1:0]     data_dnt;
    logic                 ready_dnt;
    logic                 valid_src;
    logic [OUT_WIDTH-1:0] data_src;
    logic                 ready_src;
`ifdef BUS_DOWNSIZER_LAST_EN
    logic                 last_src;
    modport master (output valid_dnt, data_dnt, ready_src,
                    input  ready_dnt, valid_src, data_src, last_src);
    modport slave  (input  valid_dnt, data_dnt, ready_src,
                    output ready_dnt, valid_src, data_src, last_src);
`else
    modport master (output valid_dnt, data_dnt, ready_src,
                    input  ready_dnt, valid_src, data_src);
    modport slave  (input  valid_dnt, data_dnt, ready_src,
                    output ready_dnt, valid_src, data_src);
`endif
endinterface

// File: rtl/bus_downsizer.sv
// bus_downsizer: serialises WIDTH-bit words into RATIO registered OUT_WIDTH-bit beats, LSB first.
// Optional registered last_src output with BUS_DOWNSIZER_LAST_EN.
module bus_downsizer #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    bus_downsizer_if.slave bus
);
    localparam int RATIO = WIDTH / OUT_WIDTH;
    localparam int CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

    typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_beat, out_fire, in_fire;

    assign last_beat     = cnt_q == LAST;
    assign out_fire      = (state_q == SEND) & bus.ready_src;
    // a new word may enter in the same cycle the final beat leaves, so words stream without bubbles
    assign bus.ready_dnt = (state_q == EMPTY) | (bus.ready_src & last_beat);
    assign in_fire       = bus.valid_dnt & bus.ready_dnt;
    assign bus.valid_src = state_q == SEND;
    assign bus.data_src  = hold_q[OUT_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        if (in_fire) begin
            state_d = SEND;
            hold_d  = bus.data_dnt;
            cnt_d   = '0;
        end else if (out_fire) begin
            state_d = last_beat ? EMPTY : SEND;
            hold_d  = last_beat ? hold_q : hold_q >> OUT_WIDTH;
            cnt_d   = last_beat ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BUS_DOWNSIZER_LAST_EN
    logic last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_q <= 1'b0;
        else      last_q <= (state_d == SEND) && (cnt_d == LAST);
    end

    assign bus.last_src = last_q;
`endif
endmodule

// File: tb/tb_bus_downsizer.sv
// tb_bus_downsizer: directed stimulus against a queue model of the expected beat stream.
module tb_bus_downsizer;
    localparam int W  = 32;
    localparam int OW = 8;
    localparam int R  = W / OW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_downsizer_if #(.WIDTH(W), .OUT_WIDTH(OW)) bus ();
    bus_downsizer #(.WIDTH(W), .OUT_WIDTH(OW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] log_q[$];
    int            log_t[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the remaining beats of the word in flight; a beat leaves on each fire, a word's beats join on accept
    always @(negedge clk) begin
        cyc_n++;
        if (!rst) begin
            exp_q.delete();
            chk("rst_valid", bus.valid_src, 0);
            chk("rst_data", bus.data_src, 0);
            chk("rst_ready", bus.ready_dnt, 1);
`ifdef BUS_DOWNSIZER_LAST_EN
            chk("rst_last", bus.last_src, 0);
`endif
        end else begin
            chk("valid", bus.valid_src, exp_q.size() != 0);
            chk("ready_dnt", bus.ready_dnt, exp_q.size() == 0 || (bus.ready_src && exp_q.size() == 1));
            if (exp_q.size() != 0) begin
                chk("data", bus.data_src, exp_q[0]);
`ifdef BUS_DOWNSIZER_LAST_EN
                chk("last", bus.last_src, exp_q.size() == 1);
`endif
            end
            if (bus.valid_src && bus.ready_src) begin
                log_q.push_back(bus.data_src);
                log_t.push_back(cyc_n);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (bus.valid_dnt && bus.ready_dnt)
                for (int k = 0; k < R; k++) exp_q.push_back(bus.data_dnt[k*OW +: OW]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        log_q.delete();
        log_t.delete();
    endtask

    task automatic offer(input logic [W-1:0] w);
        bit ok = 1'b0;
        bus.valid_dnt = 1'b1;
        bus.data_dnt  = w;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.ready_dnt;
        end
        chk("accept", ok, 1);
        @(posedge clk);
        #1;
        bus.valid_dnt = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc(1);
        chk("drain", exp_q.size(), 0);
        cyc(1);
    endtask

    task automatic check_log(input string name, input logic [63:0] exp, input int n);
        chk({name, "_len"}, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++) chk(name, log_q[i], exp[i*8 +: 8]);
    endtask

    initial begin
        bus.valid_dnt = 1'b1;
        bus.data_dnt  = 32'hFFFFFFFF;
        bus.ready_src = 1'b1;
        #1 rst = 1'b0;
        cyc(3);
        chk("rst_hold_valid", bus.valid_src, 0);
        // release with a word already offered: the first in_fire takes it
        rst = 1'b1;
        bus.data_dnt = 32'h44332211;
        cyc(1);
        bus.valid_dnt = 1'b0;
        wait_idle();
        check_log("single", 64'h44332211, 4);
        chk("single_idle", bus.valid_src, 0);

        clr();
        offer(32'h03020100);
        offer(32'h07060504);
        wait_idle();
        check_log("stream", 64'h0706050403020100, 8);
        if (log_t.size() == 8) chk("stream_span", log_t[7] - log_t[0], 7);

        clr();
        offer(32'h44332211);
        cyc(1);
        bus.ready_src = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_data", bus.data_src, 8'h22);
            chk("bp_valid", bus.valid_src, 1);
            chk("bp_ready", bus.ready_dnt, 0);
        end
        @(posedge clk);
        #1 bus.ready_src = 1'b1;
        wait_idle();
        check_log("bp", 64'h44332211, 4);

        clr();
        offer(32'h44332211);
        cyc(3);
        bus.ready_src = 1'b0;
        bus.valid_dnt = 1'b1;
        bus.data_dnt  = 32'h0B0A0908;
        repeat (2) begin
            @(negedge clk);
            chk("bpl_data", bus.data_src, 8'h44);
            chk("bpl_ready", bus.ready_dnt, 0);
        end
        @(posedge clk);
        #1 bus.ready_src = 1'b1;
        @(negedge clk);
        chk("bpl_ready_rise", bus.ready_dnt, 1);
        @(posedge clk);
        #1 bus.valid_dnt = 1'b0;
        @(negedge clk);
        chk("bpl_next", bus.data_src, 8'h08);
        wait_idle();
        check_log("bpl", 64'h0B0A090844332211, 8);

        clr();
        offer(32'h44332211);
        cyc(1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("async_valid", bus.valid_src, 0);
        check_log("pre_rst", 64'h2211, 2);
        clr();
        cyc(2);
        rst = 1'b1;
        cyc(6);
        chk("no_tail", log_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bus_downsizer.md
# bus_downsizer

Valid/ready width converter that sits directly downstream of the bus handshake register slice. It consumes full WIDTH-bit words from the slice's source side and serialises each word into RATIO narrower beats on its own valid/ready source port. It is used in front of narrow peripherals and links. Back-to-back words stream with no bubble cycles, and every output beat is registered.

## Interface
- WIDTH, 32: input word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8: output beat width.
- RATIO, WIDTH/OUT_WIDTH (derived, localparam): beats per word; must be ≥ 2.
- CNT_W, $clog2(RATIO) (derived): beat counter width.

Ports (clock and reset first):
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- valid_dnt  input  1  input word valid (driven by the upstream slice's valid_src).
- data_dnt  input  WIDTH  input word (driven by the upstream slice's data_src).
- ready_dnt  output  1  input ready (drives the upstream slice's ready_src); combinational.
- valid_src  output  1  output beat valid; registered.
- data_src  output  OUT_WIDTH  output beat; registered.
- ready_src  input  1  downstream ready.
- last_src  output  1  final beat of word; present only with BUS_DOWNSIZER_LAST_EN.

## Operation
- State:
  - hold_q[WIDTH-1:0]: the remaining word bits.
  - cnt_q[CNT_W-1:0]: index of the beat currently presented.
  - valid_src register.
- Two states, encoded by valid_src:
  - EMPTY (valid_src=0): no beat is presented.
  - SEND (valid_src=1): beat cnt_q is presented.
- Definitions:
  - out_fire = valid_src & ready_src
  - in_fire = valid_dnt & ready_dnt
  - last_beat = (cnt_q == RATIO-1)
- ready_dnt = ~valid_src | (ready_src & last_beat). The input is taken either when nothing is presented or in the same cycle the final beat leaves.
- Beat order is LSB first:
  - Beat k carries word bits [k·OUT_WIDTH +: OUT_WIDTH].
  - data_src is taken from hold_q[OUT_WIDTH-1:0].
  - hold_q shifts right by OUT_WIDTH on each non-final out_fire.
- Transitions:
  - EMPTY, in_fire: load hold_q ← data_dnt, cnt_q ← 0, go to SEND.
  - EMPTY, no in_fire: stay in EMPTY.
  - SEND, out_fire & ~last_beat: cnt_q+1, shift hold_q, stay in SEND.
  - SEND, out_fire & last_beat & in_fire: load the new word, cnt_q ← 0, stay in SEND (no bubble).
  - SEND, out_fire & last_beat & ~in_fire: go to EMPTY, cnt_q ← 0.
  - SEND, ~out_fire: all state held. data_src and valid_src stay stable (AXI-style; valid never retracts).
- data_dnt is ignored unless in_fire. valid_dnt may be high while ready_dnt is low; the word is simply not taken.
- cnt_q never exceeds RATIO-1 and wraps to 0 only on the final beat.

## Timing
- Reset (rst=0, asynchronous): valid_src=0, data_src=0, hold_q=0, cnt_q=0, last_src=0. ready_dnt therefore reads 1 during and after reset.
- Reset asserted mid-word drops the partial word; no beat of it appears after reset is released.
- Latency: a word accepted at edge N presents beat 0 on valid_src/data_src after edge N, i.e. during cycle N+1.
- Throughput with ready_src held at 1: one beat per cycle, one word per RATIO cycles, and valid_src stays continuously 1 across word boundaries.
- ready_dnt depends combinationally on ready_src and the state registers only. There is no path from valid_dnt or data_dnt to ready_dnt.
- The handshake has a combinational ready_src→ready_dnt path. A timing-critical integration places the handshake slice upstream, which already registers its own ready.

## Configuration
- BUS_DOWNSIZER_LAST_EN defined:
  - Adds output last_src (1 bit, registered).
  - last_src = 1 exactly while valid_src=1 and the presented beat is beat RATIO-1; 0 otherwise.
  - Held stable under backpressure like data_src. Reset value 0.
- BUS_DOWNSIZER_LAST_EN undefined:
  - Port last_src does not exist.
  - All other behaviour is identical.

## Test plan
- Reset: hold rst=0 with valid_dnt=1 and data_dnt=32'hFFFFFFFF -> valid_src=0, data_src=0, ready_dnt=1. After releasing rst, the first in_fire takes the word.
- Single word: ready_src=1, one word 32'h44332211 -> beats 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles, then valid_src=0. last_src=1 only on 8'h44 (with macro).
- Streaming: words 32'h03020100 and 32'h07060504 offered back-to-back with ready_src=1 -> 8 consecutive beats 8'h00..8'h07 with valid_src never low. ready_dnt=1 only in the final-beat cycles.
- Backpressure: ready_src=0 for 3 cycles while beat 8'h22 is presented -> data_src=8'h22 and valid_src=1 remain stable, and ready_dnt=0 throughout. The sequence resumes at 8'h33.
- Backpressure on final beat: ready_src=0 during beat 8'h44 with valid_dnt=1 -> ready_dnt=0 and no new word taken. When ready_src rises, ready_dnt=1 in that same cycle and the next word's beat 0 appears the following cycle.
- Mid-word reset: assert rst=0 asynchronously after beat 8'h22 -> valid_src drops immediately, without waiting for a clock edge. After release, no 8'h33 or 8'h44 beat ever appears.
